// File: rtl/regs_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
package regs_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REG_ZERO = 0;

   function automatic int aw(input int nreg);
      return $clog2(nreg);
   endfunction

endpackage

// File: rtl/regs_sb.sv
// Busy-bit scoreboard: one pending-write flag per register, issue sets, writeback clears.
module regs_sb
   import regs_pkg::*;
#(
   parameter  int NREG   = 32,
   parameter  int NRP    = 2,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = aw(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [NRP*AW-1:0] raddr,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_rd,
   input  logic              flush,
   output logic [NRP-1:0]    rbusy,
   output logic [AW:0]       busy_cnt
);

   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [AW-1:0]   ra;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      busy_d = '0;
      cnt_d  = '0;
      if (!flush) begin
         // Set beats clear: the write retires an older instruction, the new issue is still in flight.
         for (int n = 1; n < NREG; n++) begin
            busy_d[n] = (iss_en && iss_rd == AW'(n)) ||
                        (busy_q[n] && !(we && waddr == AW'(n)));
         end
      end
      for (int n = 1; n < NREG; n++) begin
         cnt_d = cnt_d + {{AW{1'b0}}, busy_d[n]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rbusy = '0;
      ra    = '0;
      for (int i = 0; i < NRP; i++) begin
         ra       = raddr[i*AW +: AW];
         rbusy[i] = busy_q[ra];
         if (BYPASS && we && waddr == ra && ra != AW'(REG_ZERO) &&
             !(iss_en && iss_rd == ra)) begin
            rbusy[i] = 1'b0;
         end
      end
   end

   assign busy_cnt = cnt_q;

endmodule

// File: rtl/regs_mp_sb.sv
// Multi-read-port integer register file (r0 = 0) with optional write bypass and busy scoreboard.
module regs_mp_sb
   import regs_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREG   = 32,
   parameter  int NRP    = 2,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = aw(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NRP*AW-1:0]   raddr,
   output logic [NRP*XLEN-1:0] rdata,
   output logic [NRP-1:0]      rbusy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic [AW:0]         busy_cnt
);

   logic [XLEN-1:0] rf_q [NREG];
   logic [AW-1:0]   ra;

   // NOTE: the array is reset explicitly because reset must make every register read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NREG; n++) rf_q[n] <= '0;
      end else if (we && waddr != AW'(REG_ZERO)) begin
         rf_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      ra    = '0;
      for (int i = 0; i < NRP; i++) begin
         ra = raddr[i*AW +: AW];
         if (ra == AW'(REG_ZERO)) begin
            rdata[i*XLEN +: XLEN] = '0;
         end else if (BYPASS && we && waddr == ra) begin
            rdata[i*XLEN +: XLEN] = wdata;
         end else begin
            rdata[i*XLEN +: XLEN] = rf_q[ra];
         end
      end
   end

   regs_sb #(
      .NREG   (NREG),
      .NRP    (NRP),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .raddr    (raddr),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .flush    (flush),
      .rbusy    (rbusy),
      .busy_cnt (busy_cnt)
   );

endmodule

// File: tb/tb_regs_mp_sb.sv
// Directed bench: one BYPASS=1 and one BYPASS=0 instance share all inputs.
module tb_regs_mp_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRP  = 2;
   localparam int AW   = 5;

   logic                clk = 1'b0;
   logic                rst, we, iss_en, flush;
   logic [AW-1:0]       waddr, iss_rd, ra0, ra1;
   logic [XLEN-1:0]     wdata;
   logic [NRP*AW-1:0]   raddr;
   logic [NRP*XLEN-1:0] rdata_b, rdata_n;
   logic [NRP-1:0]      rbusy_b, rbusy_n;
   logic [AW:0]         cnt_b, cnt_n;

   int n_vec = 0;
   int n_err = 0;

   assign raddr = {ra1, ra0};

   always #5 clk = ~clk;

   regs_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
      .rdata(rdata_b), .rbusy(rbusy_b), .iss_en(iss_en), .iss_rd(iss_rd),
      .flush(flush), .busy_cnt(cnt_b)
   );

   regs_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
      .rdata(rdata_n), .rbusy(rbusy_n), .iss_en(iss_en), .iss_rd(iss_rd),
      .flush(flush), .busy_cnt(cnt_n)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle away from it; inputs return to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      rst = 0; we = 0; iss_en = 0; flush = 0;
      #1;
   endtask

   initial begin
      rst = 1; we = 0; iss_en = 0; flush = 0;
      waddr = '0; wdata = '0; iss_rd = '0; ra0 = '0; ra1 = '0;
      tick();
      check("reset_cnt", 64'(cnt_b), 64'd0);

      // 1. reset clears written data
      we = 1; waddr = 5; wdata = 32'hDEADBEEF;
      tick();
      ra0 = 5; #1;
      check("r5_written", 64'(rdata_b[31:0]), 64'hDEADBEEF);
      rst = 1;
      tick();
      check("r5_after_rst", 64'(rdata_b[31:0]), 64'd0);
      check("r5_after_rst_nb", 64'(rdata_n[31:0]), 64'd0);
      check("rbusy_after_rst", 64'(rbusy_b), 64'd0);
      check("cnt_after_rst", 64'(cnt_b), 64'd0);

      // 2. r0 hardwiring
      we = 1; waddr = 0; wdata = 32'hFFFFFFFF; iss_en = 1; iss_rd = 0;
      ra0 = 0; ra1 = 0; #1;
      check("r0_bypass_blocked", 64'(rdata_b[31:0]), 64'd0);
      tick();
      check("r0_read", 64'(rdata_b[63:32]), 64'd0);
      check("r0_rbusy", 64'(rbusy_b), 64'd0);
      check("r0_cnt", 64'(cnt_b), 64'd0);

      // 3. bypass vs no bypass
      we = 1; waddr = 7; wdata = 32'h12345678; ra0 = 7; ra1 = 7; #1;
      check("byp_port0", 64'(rdata_b[31:0]), 64'h12345678);
      check("byp_port1", 64'(rdata_b[63:32]), 64'h12345678);
      check("nobyp_old", 64'(rdata_n[31:0]), 64'd0);
      tick();
      check("nobyp_new", 64'(rdata_n[31:0]), 64'h12345678);

      // 4. scoreboard life cycle
      iss_en = 1; iss_rd = 3;
      tick();
      ra0 = 3; ra1 = 7; #1;
      check("r3_busy", 64'(rbusy_b), 64'b01);
      check("r3_cnt", 64'(cnt_b), 64'd1);
      we = 1; waddr = 3; wdata = 32'h000000AA; #1;
      check("r3_wb_byp_rbusy", 64'(rbusy_b), 64'b00);
      check("r3_wb_nobyp_rbusy", 64'(rbusy_n), 64'b01);
      tick();
      check("r3_clear_rbusy", 64'(rbusy_b), 64'b00);
      check("r3_clear_cnt", 64'(cnt_b), 64'd0);
      check("r3_data", 64'(rdata_b[31:0]), 64'hAA);

      // 5. same-cycle set and clear keeps the register busy
      iss_en = 1; iss_rd = 9;
      tick();
      check("r9_cnt", 64'(cnt_b), 64'd1);
      we = 1; waddr = 9; wdata = 32'h99; iss_en = 1; iss_rd = 9;
      tick();
      ra0 = 9; #1;
      check("r9_still_busy", 64'(rbusy_b[0]), 64'd1);
      check("r9_cnt_same", 64'(cnt_n), 64'd1);
      check("r9_data", 64'(rdata_b[31:0]), 64'h99);
      check("two_ports", 64'(rdata_n[63:32]), 64'h12345678);

      // 6. flush
      we = 1; waddr = 9; wdata = 32'h99;
      tick();
      check("r9_released", 64'(cnt_b), 64'd0);
      iss_en = 1; iss_rd = 1; tick();
      iss_en = 1; iss_rd = 2; tick();
      iss_en = 1; iss_rd = 4; tick();
      ra0 = 2; ra1 = 4; #1;
      check("three_busy_cnt", 64'(cnt_b), 64'd3);
      check("three_busy_rbusy", 64'(rbusy_n), 64'b11);
      flush = 1; iss_en = 1; iss_rd = 6; we = 1; waddr = 4; wdata = 32'h44;
      tick();
      ra0 = 6; ra1 = 4; #1;
      check("flush_cnt", 64'(cnt_b), 64'd0);
      check("flush_rbusy", 64'(rbusy_b), 64'b00);
      check("flush_write_kept", 64'(rdata_n[63:32]), 64'h44);
      ra0 = 1; ra1 = 2; #1;
      check("flush_rbusy_r1_r2", 64'(rbusy_n), 64'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
